// File: rtl/wm_pkg.sv
// wm_pkg: phase codes shared with the washing-machine controller, default
// phase timing constants and the command decode helpers.
package wm_pkg;

  // Phase codes match the controller's state codes so both sides agree on "phase".
  localparam logic [2:0] PH_IDLE_CODE  = 3'd0;
  localparam logic [2:0] PH_FILL_CODE  = 3'd2;
  localparam logic [2:0] PH_HEAT_CODE  = 3'd3;
  localparam logic [2:0] PH_WASH_CODE  = 3'd4;
  localparam logic [2:0] PH_RINSE_CODE = 3'd5;
  localparam logic [2:0] PH_SPIN_CODE  = 3'd6;

  localparam int CNT_W_DEF        = 8;
  localparam int FILL_TIMEOUT_DEF = 64;
  localparam int HEAT_TIMEOUT_DEF = 128;
  localparam int WASH_CYCLES_DEF  = 32;
  localparam int RINSE_CYCLES_DEF = 16;
  localparam int SPIN_CYCLES_DEF  = 16;

  typedef enum logic [2:0] {
    PH_IDLE  = PH_IDLE_CODE,
    PH_FILL  = PH_FILL_CODE,
    PH_HEAT  = PH_HEAT_CODE,
    PH_WASH  = PH_WASH_CODE,
    PH_RINSE = PH_RINSE_CODE,
    PH_SPIN  = PH_SPIN_CODE
  } phase_e;

  // cmd = {spin, rinse, wash, heat, fill}; anything other than one-hot is IDLE.
  function automatic phase_e decode_cmd(input logic [4:0] cmd);
    phase_e ph;
    case (cmd)
      5'b00001: ph = PH_FILL;
      5'b00010: ph = PH_HEAT;
      5'b00100: ph = PH_WASH;
      5'b01000: ph = PH_RINSE;
      5'b10000: ph = PH_SPIN;
      default:  ph = PH_IDLE;
    endcase
    return ph;
  endfunction

  // True when two or more command bits are set.
  function automatic logic multi_cmd(input logic [4:0] cmd);
    return (cmd & (cmd - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/wm_sensor_sync.sv
// wm_sensor_sync: two-flop synchronizer for a raw asynchronous sensor.
// With WM_SENSOR_DEBOUNCE_EN defined, a debouncer follows the synchronizer:
// the output only changes after DEBOUNCE_CYCLES consecutive synchronized
// samples that disagree with it, so shorter glitches never reach the output.
module wm_sensor_sync
`ifdef WM_SENSOR_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clock,
  input  logic reset_n,
  input  logic sensor_raw,
  output logic sensor_s
);

  logic [1:0] sync_q;

  // Two-stage metastability synchronizer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], sensor_raw};
  end

`ifdef WM_SENSOR_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt_q;
  logic            db_q;

  // Count consecutive samples that differ from the output; flip after enough of them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (sync_q[1] == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_q     <= sync_q[1];
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign sensor_s = db_q;
`else
  assign sensor_s = sync_q[1];
`endif

endmodule

// File: rtl/wm_plant_responder.sv
// wm_plant_responder: appliance-side model answering the washing-machine
// controller. Decodes the one-hot operation commands into a phase, times the
// phase with one shared saturating up-counter and returns the status flags.
// Optional sensor debouncing is enabled by defining WM_SENSOR_DEBOUNCE_EN.
//
// phase  | meaning
// IDLE   | no command, or several commands at once (cmd_Error); counter held at 0
// FILL   | sig_Full follows level; sig_Time_Out if level never seen by FILL_TIMEOUT
// HEAT   | sig_Temperature follows temp; sig_Time_Out if never seen by HEAT_TIMEOUT
// WASH   | sig_Wash_Completed from WASH_CYCLES edges after entry
// RINSE  | sig_Rinse_Completed from RINSE_CYCLES edges after entry
// SPIN   | sig_Spin_Completed from SPIN_CYCLES edges after entry
module wm_plant_responder
  import wm_pkg::*;
#(
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF,
  parameter int HEAT_TIMEOUT = HEAT_TIMEOUT_DEF,
  parameter int WASH_CYCLES  = WASH_CYCLES_DEF,
  parameter int RINSE_CYCLES = RINSE_CYCLES_DEF,
  parameter int SPIN_CYCLES  = SPIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
`ifdef WM_SENSOR_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       fill_Water_Operation,
  input  logic       heat_Water_Operation,
  input  logic       wash_Operation,
  input  logic       rinse_Operation,
  input  logic       spin_Operation,
  input  logic       level_Sensor,
  input  logic       temp_Sensor,
  output logic       sig_Full,
  output logic       sig_Temperature,
  output logic       sig_Time_Out,
  output logic       sig_Wash_Completed,
  output logic       sig_Rinse_Completed,
  output logic       sig_Spin_Completed,
  output logic       cmd_Error,
  output logic [2:0] phase
);

  // The counter reads N-1 on the edge that completes N edges in the phase.
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] FILL_TERM  = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HEAT_TERM  = CNT_W'(HEAT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WASH_TERM  = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RINSE_TERM = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_TERM  = CNT_W'(SPIN_CYCLES - 1);

  logic [4:0]       cmd;
  logic             level_s, temp_s;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             full_q, full_d, temp_q, temp_d, tout_q, tout_d;
  logic             wash_q, wash_d, rinse_q, rinse_d, spin_q, spin_d;
  logic             err_q, err_d;
  // Sticky "sensor seen this phase": freezes the counter and blocks the timeout.
  logic             seen_q, seen_d;

  assign cmd = {spin_Operation, rinse_Operation, wash_Operation,
                heat_Water_Operation, fill_Water_Operation};

`ifdef WM_SENSOR_DEBOUNCE_EN
  wm_sensor_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_level_sync (
    .clock(clock), .reset_n(reset_n), .sensor_raw(level_Sensor), .sensor_s(level_s));
  wm_sensor_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_temp_sync (
    .clock(clock), .reset_n(reset_n), .sensor_raw(temp_Sensor), .sensor_s(temp_s));
`else
  wm_sensor_sync u_level_sync (
    .clock(clock), .reset_n(reset_n), .sensor_raw(level_Sensor), .sensor_s(level_s));
  wm_sensor_sync u_temp_sync (
    .clock(clock), .reset_n(reset_n), .sensor_raw(temp_Sensor), .sensor_s(temp_s));
`endif

  // Phase, counter and every status output are registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      temp_q  <= 1'b0;
      tout_q  <= 1'b0;
      wash_q  <= 1'b0;
      rinse_q <= 1'b0;
      spin_q  <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      temp_q  <= temp_d;
      tout_q  <= tout_d;
      wash_q  <= wash_d;
      rinse_q <= rinse_d;
      spin_q  <= spin_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
    end
  end

  // Next phase and per-phase status; a phase change clears counter and flags.
  always_comb begin
    phase_d = decode_cmd(cmd);
    err_d   = multi_cmd(cmd);
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d   = '0;
    full_d  = 1'b0;
    temp_d  = 1'b0;
    tout_d  = 1'b0;
    wash_d  = 1'b0;
    rinse_d = 1'b0;
    spin_d  = 1'b0;
    seen_d  = 1'b0;
    if (phase_d == phase_q) begin
      case (phase_q)
        PH_FILL: begin
          full_d = level_s;
          seen_d = seen_q | level_s;
          tout_d = tout_q | (!seen_q && !level_s && cnt_q >= FILL_TERM);
          cnt_d  = seen_q ? cnt_q : cnt_inc;
        end
        PH_HEAT: begin
          temp_d = temp_s;
          seen_d = seen_q | temp_s;
          tout_d = tout_q | (!seen_q && !temp_s && cnt_q >= HEAT_TERM);
          cnt_d  = seen_q ? cnt_q : cnt_inc;
        end
        PH_WASH: begin
          cnt_d  = cnt_inc;
          wash_d = wash_q | (cnt_q >= WASH_TERM);
        end
        PH_RINSE: begin
          cnt_d   = cnt_inc;
          rinse_d = rinse_q | (cnt_q >= RINSE_TERM);
        end
        PH_SPIN: begin
          cnt_d  = cnt_inc;
          spin_d = spin_q | (cnt_q >= SPIN_TERM);
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign sig_Full            = full_q;
  assign sig_Temperature     = temp_q;
  assign sig_Time_Out        = tout_q;
  assign sig_Wash_Completed  = wash_q;
  assign sig_Rinse_Completed = rinse_q;
  assign sig_Spin_Completed  = spin_q;
  assign cmd_Error           = err_q;
  assign phase               = phase_q;

endmodule

// File: tb/tb_wm_plant_responder.sv
// tb_wm_plant_responder: directed and randomized stimulus for the plant
// responder, checked every edge against an edge-counting reference model.
module tb_wm_plant_responder;

  localparam int FILL_T  = 8;
  localparam int HEAT_T  = 12;
  localparam int WASH_N  = 4;
  localparam int RINSE_N = 16;
  localparam int SPIN_N  = 6;
  localparam int DB_N    = 4;
`ifdef WM_SENSOR_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  localparam bit [2:0] P_IDLE = 3'd0, P_FILL = 3'd2, P_HEAT = 3'd3,
                       P_WASH = 3'd4, P_RINSE = 3'd5, P_SPIN = 3'd6;

  logic       clock, reset_n;
  logic       fill_Water_Operation, heat_Water_Operation, wash_Operation;
  logic       rinse_Operation, spin_Operation, level_Sensor, temp_Sensor;
  logic       sig_Full, sig_Temperature, sig_Time_Out;
  logic       sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed;
  logic       cmd_Error;
  logic [2:0] phase;

  wm_plant_responder #(
    .FILL_TIMEOUT(FILL_T), .HEAT_TIMEOUT(HEAT_T), .WASH_CYCLES(WASH_N),
    .RINSE_CYCLES(RINSE_N), .SPIN_CYCLES(SPIN_N), .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .fill_Water_Operation(fill_Water_Operation),
    .heat_Water_Operation(heat_Water_Operation),
    .wash_Operation(wash_Operation), .rinse_Operation(rinse_Operation),
    .spin_Operation(spin_Operation), .level_Sensor(level_Sensor),
    .temp_Sensor(temp_Sensor), .sig_Full(sig_Full),
    .sig_Temperature(sig_Temperature), .sig_Time_Out(sig_Time_Out),
    .sig_Wash_Completed(sig_Wash_Completed),
    .sig_Rinse_Completed(sig_Rinse_Completed),
    .sig_Spin_Completed(sig_Spin_Completed), .cmd_Error(cmd_Error),
    .phase(phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: k = edges since the edge that entered the phase.
  bit [2:0] m_ph;
  int       k, n_edge;
  bit       m_full, m_temp, m_tout, m_wash, m_rinse, m_spin, m_err, m_seen;
  bit       raw_l[$], raw_t[$];
  bit       db_l, db_t;
  int       n_chk, n_pass;

  function automatic bit synced(input bit is_temp, input int x);
    if (x < 2) return 1'b0;
    return is_temp ? raw_t[x-2] : raw_l[x-2];
  endfunction

  // Debounced value flips once the last DB_N synchronized samples all disagree.
  function automatic bit db_next(input bit is_temp, input bit cur, input int e);
    for (int j = 0; j < DB_N; j++)
      if (synced(is_temp, e - j) == cur) return cur;
    return ~cur;
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; k = 0; n_edge = 0;
    {m_full, m_temp, m_tout, m_wash, m_rinse, m_spin, m_err, m_seen} = '0;
    raw_l.delete(); raw_t.delete();
    db_l = 1'b0; db_t = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n_edge, obs, exp);
  endtask

  task automatic check_all();
    chk("phase", 8'(phase), 8'(m_ph));
    chk("cmd_Error", 8'(cmd_Error), 8'(m_err));
    chk("sig_Full", 8'(sig_Full), 8'(m_full));
    chk("sig_Temperature", 8'(sig_Temperature), 8'(m_temp));
    chk("sig_Time_Out", 8'(sig_Time_Out), 8'(m_tout));
    chk("sig_Wash_Completed", 8'(sig_Wash_Completed), 8'(m_wash));
    chk("sig_Rinse_Completed", 8'(sig_Rinse_Completed), 8'(m_rinse));
    chk("sig_Spin_Completed", 8'(sig_Spin_Completed), 8'(m_spin));
  endtask

  // Advance one clock edge: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    bit ls, ts;
    bit [4:0] c;
    bit [2:0] ph;
    int nc, e;
    e = n_edge;
    raw_l.push_back(level_Sensor);
    raw_t.push_back(temp_Sensor);
    if (DB_ON) begin
      ls = db_l; ts = db_t;
      db_l = db_next(1'b0, db_l, e);
      db_t = db_next(1'b1, db_t, e);
    end else begin
      ls = synced(1'b0, e);
      ts = synced(1'b1, e);
    end
    c  = {spin_Operation, rinse_Operation, wash_Operation,
          heat_Water_Operation, fill_Water_Operation};
    nc = $countones(c);
    ph = P_IDLE;
    if (nc == 1)
      ph = c[0] ? P_FILL : c[1] ? P_HEAT : c[2] ? P_WASH : c[3] ? P_RINSE : P_SPIN;
    m_err = (nc > 1);
    if (ph != m_ph) begin
      m_ph = ph; k = 0; m_seen = 0;
      {m_full, m_temp, m_tout, m_wash, m_rinse, m_spin} = '0;
    end else begin
      k++;
      case (ph)
        P_FILL: begin
          if (!m_seen && !ls && k >= FILL_T) m_tout = 1'b1;
          m_full = ls;
          if (ls) m_seen = 1'b1;
        end
        P_HEAT: begin
          if (!m_seen && !ts && k >= HEAT_T) m_tout = 1'b1;
          m_temp = ts;
          if (ts) m_seen = 1'b1;
        end
        P_WASH:  m_wash  = (k >= WASH_N);
        P_RINSE: m_rinse = (k >= RINSE_N);
        P_SPIN:  m_spin  = (k >= SPIN_N);
        default: ;
      endcase
    end
    @(posedge clock);
    #1;
    n_edge++;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [4:0] c;
    int r, len;
    n_chk = 0; n_pass = 0;
    {fill_Water_Operation, heat_Water_Operation, wash_Operation,
     rinse_Operation, spin_Operation, level_Sensor, temp_Sensor} = '0;
    reset_n = 1'b0;
    model_reset();
    #3 check_all();
    @(posedge clock); @(posedge clock); #2 reset_n = 1'b1;

    // Wash: completion from edge 4, dropped on the edge after the command goes away.
    wash_Operation = 1; repeat (8) tick();
    wash_Operation = 0; repeat (2) tick();

    // Fill with no level: timeout at edge 8, then level arrives, timeout stays.
    fill_Water_Operation = 1; repeat (10) tick();
    level_Sensor = 1; repeat (4) tick();
    fill_Water_Operation = 0; level_Sensor = 0; repeat (3) tick();

    // Fill with level rising raw at edge 6: full at edge 8, never a timeout, even after level drops.
    fill_Water_Operation = 1; repeat (6) tick();
    level_Sensor = 1; repeat (6) tick();
    level_Sensor = 0; repeat (12) tick();
    fill_Water_Operation = 0; repeat (2) tick();

    // Heat: 2-cycle glitch, then stable high.
    heat_Water_Operation = 1; repeat (3) tick();
    temp_Sensor = 1; repeat (2) tick();
    temp_Sensor = 0; repeat (4) tick();
    temp_Sensor = 1; repeat (9) tick();
    heat_Water_Operation = 0; temp_Sensor = 0; repeat (3) tick();

    // Heat timeout.
    heat_Water_Operation = 1; repeat (15) tick();
    heat_Water_Operation = 0; repeat (2) tick();

    // Two commands: error, IDLE; clearing one restarts the wash count.
    wash_Operation = 1; spin_Operation = 1; repeat (3) tick();
    spin_Operation = 0; repeat (6) tick();
    wash_Operation = 0; tick();

    // Rinse interrupted by reset at count 10, then completes 16 edges after restart.
    rinse_Operation = 1; repeat (11) tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clock); @(posedge clock); #2 reset_n = 1'b1;
    repeat (18) tick();
    rinse_Operation = 0; tick();

    // Spin.
    spin_Operation = 1; repeat (8) tick();
    spin_Operation = 0; tick();

    // Randomized command segments with wandering sensors.
    for (int seg = 0; seg < 40; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 8) c = 5'b00001 << $urandom_range(0, 4);
      else if (r == 8) c = 5'b0;
      else begin
        c = 5'($urandom);
        if ($countones(c) < 2) c = 5'b00101;
      end
      {spin_Operation, rinse_Operation, wash_Operation,
       heat_Water_Operation, fill_Water_Operation} = c;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) level_Sensor = ~level_Sensor;
        if ($urandom_range(0, 5) == 0) temp_Sensor = ~temp_Sensor;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wm_plant_responder.md
Name: wm_plant_responder

Overview:
- Appliance-side responder for the washing-machine controller.
- Consumes the controller's one-hot operation commands and the raw level and temperature sensors.
- Produces the status inputs the controller expects: sig_Full, sig_Temperature, sig_Time_Out, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed.
- Times each phase with one shared cycle counter.

Parameters:
- FILL_TIMEOUT, 64, edges allowed in fill before sig_Time_Out.
- HEAT_TIMEOUT, 128, edges allowed in heat before sig_Time_Out.
- WASH_CYCLES, 32, edges of wash before sig_Wash_Completed.
- RINSE_CYCLES, 16, edges of rinse before sig_Rinse_Completed.
- SPIN_CYCLES, 16, edges of spin before sig_Spin_Completed.
- CNT_W, 8, counter width; every cycle/timeout parameter must be ≤ 2^CNT_W-1.
- DEBOUNCE_CYCLES, 4, stable samples required when WM_SENSOR_DEBOUNCE_EN is defined.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fill_Water_Operation  in  1  fill command.
- heat_Water_Operation  in  1  heat command.
- wash_Operation  in  1  wash command.
- rinse_Operation  in  1  rinse command.
- spin_Operation  in  1  spin command.
- level_Sensor  in  1  raw async water-level-reached.
- temp_Sensor  in  1  raw async target-temperature-reached.
- sig_Full  out  1  water full, fill phase only.
- sig_Temperature  out  1  temperature reached, heat phase only.
- sig_Time_Out  out  1  fill/heat timeout.
- sig_Wash_Completed  out  1  wash phase done.
- sig_Rinse_Completed  out  1  rinse phase done.
- sig_Spin_Completed  out  1  spin phase done.
- cmd_Error  out  1  more than one command high.
- phase  out  3  current phase encoding.

Behaviour:
- Reset: every output is 0; phase = IDLE; counter = 0. Reset asserted mid-phase clears everything immediately; operation resumes from IDLE on the first edge after release.
- Phase decode, each edge:
  - no command high -> IDLE.
  - exactly one command high -> that phase (FILL, HEAT, WASH, RINSE, SPIN).
  - two or more commands high -> IDLE, and cmd_Error = 1 registered, held while the condition persists.
- Phase change (decoded phase ≠ registered phase):
  - counter loads 0.
  - all sig_* outputs clear on that same edge.
- Same phase: counter increments, saturating at 2^CNT_W-1.
- All outputs are registered; no combinational path from input to output.
- Sensors pass through wm_sensor_sync (2-flop synchronizer), giving 2 edges of latency from a raw sensor to the internal level_s/temp_s.
- FILL:
  - sig_Full follows level_s while in FILL.
  - If level_s is still 0 when the counter reaches FILL_TIMEOUT, sig_Time_Out rises on that edge and is held until phase change.
  - Once sig_Full = 1, the counter freezes and no timeout can occur.
  - level_s rising on the timeout edge: sig_Full = 1, sig_Time_Out stays 0.
  - sig_Full falling after being set does not re-arm the timeout.
- HEAT: identical to FILL, using temp_s, sig_Temperature and HEAT_TIMEOUT.
- WASH / RINSE / SPIN:
  - Completion signal rises exactly N edges after the edge that first decodes the phase (N = WASH_CYCLES / RINSE_CYCLES / SPIN_CYCLES).
  - It is held as a level until phase change.
  - No timeout in these phases.
- IDLE: all sig_* = 0; counter held at 0.
- Outputs belonging to any other phase are always 0.

Optional Feature:
- Macro: WM_SENSOR_DEBOUNCE_EN.
- Defined: wm_sensor_sync adds a debouncer after the synchronizer. The output changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples, so total latency is 2 + DEBOUNCE_CYCLES edges. Glitches shorter than that are suppressed.
- Undefined: synchronizer only; latency is 2 edges.

Decomposition:
- Shared package wm_pkg holds:
  - the phase encoding localparams (IDLE=0, FILL=2, HEAT=3, WASH=4, RINSE=5, SPIN=6, matching the controller state codes);
  - default cycle constants;
  - the CNT_W default.
- One sub-module, wm_sensor_sync (synchronizer plus optional debouncer), instantiated twice: level and temp.

Test Plan:
- WASH_CYCLES=4; hold wash_Operation=1 from edge 0 -> sig_Wash_Completed=0 at edges 1-3, =1 from edge 4, held; drop command -> 0 on the next edge.
- FILL_TIMEOUT=8; fill_Water_Operation=1, level_Sensor=0 -> sig_Time_Out=1 at edge 8, sig_Full=0; then level_Sensor=1 -> sig_Full=1 after 2 edges, sig_Time_Out stays 1.
- FILL_TIMEOUT=8; level_Sensor rises raw at edge 6 -> sig_Full=1 at edge 8, sig_Time_Out never asserts.
- wash_Operation and spin_Operation both 1 -> cmd_Error=1, phase=IDLE, all sig_*=0; clearing spin -> wash count restarts from 0.
- RINSE_CYCLES=16; reset_n pulsed low at count 10 during rinse -> outputs 0 immediately; after release with rinse still high -> sig_Rinse_Completed 16 edges later.
- With WM_SENSOR_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle temp_Sensor glitch in HEAT -> sig_Temperature stays 0; a stable high -> sig_Temperature=1 six edges after the raw rise.
